// File: rtl/rr_enc8to3_arbiter.sv
// Round-robin arbiter for 8 requesters: encodes the winner to a 3-bit address, holds the
// grant until done, request drop or hold limit, then rotates priority past the winner.
module rr_enc8to3_arbiter #(
    parameter int unsigned HOLD_MAX = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic       grant_valid,
    output logic [2:0] grant_addr,
    output logic [7:0] grant_onehot,
    output logic       timeout
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    localparam bit          has_limit = (HOLD_MAX != 0);
    localparam int unsigned limit_int = has_limit ? HOLD_MAX - 1 : 0;
    localparam int unsigned sat_int   = has_limit ? HOLD_MAX : (2 ** CNT_W) - 1;

    localparam logic [CNT_W-1:0] limit_cnt = CNT_W'(limit_int);
    localparam logic [CNT_W-1:0] sat_cnt   = CNT_W'(sat_int);

    state_e           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       addr_q, addr_d;
    logic             valid_q, valid_d;
    logic [7:0]       onehot_q, onehot_d;
    logic             timeout_q, timeout_d;

    logic       found;
    logic [2:0] sel;
    logic [2:0] idx;
    logic       at_limit;

    // Walk the search order backwards so the entry closest to ptr is the last one kept.
    always_comb begin
        found = 1'b0;
        sel   = ptr_q;
        idx   = '0;
        for (int i = 7; i >= 0; i--) begin
            idx = ptr_q + 3'(i);
            if (req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign at_limit = has_limit && (cnt_q == limit_cnt);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        valid_d   = valid_q;
        onehot_d  = onehot_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    addr_d   = sel;
                    onehot_d = 8'b1 << sel;
                    valid_d  = 1'b1;
                    cnt_d    = '0;
                    state_d  = StGrant;
                end
            end
            StGrant: begin
                if (done || !req[addr_q] || at_limit) begin
                    valid_d   = 1'b0;
                    onehot_d  = '0;
                    ptr_d     = addr_q + 3'd1;
                    state_d   = StIdle;
                    // Only a purely forced release is flagged; done wins on the limit cycle.
                    timeout_d = at_limit && !done && req[addr_q];
                end else if (cnt_q != sat_cnt) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            valid_q   <= 1'b0;
            onehot_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            valid_q   <= valid_d;
            onehot_q  <= onehot_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant_valid  = valid_q;
    assign grant_addr   = addr_q;
    assign grant_onehot = onehot_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_rr_enc8to3_arbiter.sv
// Scoreboard bench: stimulus queues expected grants {addr, length, timeout}; a negedge
// monitor closes each grant when grant_valid drops and compares against the queue head.
module tb_rr_enc8to3_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic       grant_valid;
    logic [2:0] grant_addr;
    logic [7:0] grant_onehot;
    logic       timeout;

    always #5 clk = ~clk;

    rr_enc8to3_arbiter #(
        .HOLD_MAX(4),
        .CNT_W   (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .grant_valid (grant_valid),
        .grant_addr  (grant_addr),
        .grant_onehot(grant_onehot),
        .timeout     (timeout)
    );

    typedef struct {
        logic [2:0] addr;
        int         len;
        logic       to;
    } rec_t;

    rec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input int a, input int len, input logic to);
        exp_q.push_back('{addr: 3'(a), len: len, to: to});
    endtask

    // Monitor
    logic       prev_valid = 1'b0;
    logic [7:0] prev_req   = '0;
    logic [2:0] cur_addr   = '0;
    int         cur_len    = 0;
    int         wait_cnt[8];
    logic [7:0] exp_oh;
    rec_t       r;
    bit         starved;

    initial foreach (wait_cnt[i]) wait_cnt[i] = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            exp_oh = grant_valid ? (8'b1 << grant_addr) : 8'h00;
            check("onehot_consistent", grant_onehot, exp_oh);
            if (grant_valid) begin
                if (!prev_valid) begin
                    cur_addr = grant_addr;
                    cur_len  = 1;
                    check("grant_req_sampled", prev_req[grant_addr], 1);
                    starved = 1'b0;
                    for (int i = 0; i < 8; i++) begin
                        if (i == int'(grant_addr)) wait_cnt[i] = 0;
                        else if (prev_req[i]) wait_cnt[i]++;
                        else wait_cnt[i] = 0;
                        if (wait_cnt[i] > 7) starved = 1'b1;
                    end
                    check("no_starvation", starved, 0);
                end else begin
                    cur_len++;
                    check("addr_stable", grant_addr, cur_addr);
                end
                check("timeout_during_grant", timeout, 0);
            end else if (prev_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: got addr %0d len %0d, expected none",
                             cur_addr, cur_len);
                end else begin
                    r = exp_q.pop_front();
                    check("grant_addr", cur_addr, r.addr);
                    check("grant_len", cur_len, r.len);
                    check("release_timeout", timeout, r.to);
                end
            end else begin
                check("timeout_idle", timeout, 0);
            end
            prev_valid = grant_valid;
            prev_req   = req;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset with all requests high
        rst_n = 1'b0;
        req   = 8'hFF;
        done  = 1'b0;
        tick(2);
        check("reset_valid", grant_valid, 0);
        check("reset_addr", grant_addr, 0);
        check("reset_onehot", grant_onehot, 0);
        check("reset_timeout", timeout, 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // 2: rotation 0..7,0, done on every grant cycle
        for (int k = 0; k < 9; k++) begin
            expect_grant(k % 8, 1, 1'b0);
            tick(1);
            done = 1'b1;
            tick(1);
            done = 1'b0;
        end
        req = 8'h00;

        // 3: grant 5 so ptr=6, then 5 and 0 requesting -> 0 wins
        req = 8'h20;
        expect_grant(5, 1, 1'b0);
        tick(1);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        req  = 8'h21;
        expect_grant(0, 1, 1'b0);
        tick(1);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        req  = 8'h00;

        // 4: forced release after 4 cycles, then re-grant of 3
        // 5a: done on the 4th cycle of the re-grant -> no timeout
        req = 8'h08;
        expect_grant(3, 4, 1'b1);
        expect_grant(3, 4, 1'b0);
        tick(1);
        tick(4);
        tick(1);
        tick(3);
        done = 1'b1;
        tick(1);
        done = 1'b0;

        // 5b: req[3] drops during the second grant cycle
        expect_grant(3, 2, 1'b0);
        tick(2);
        req = 8'h00;
        tick(1);

        // 6: reset during grant of 5, then 0 and 5 requesting -> 0
        req = 8'h20;
        expect_grant(5, 2, 1'b0);
        tick(2);
        rst_n = 1'b0;
        tick(1);
        check("midreset_valid", grant_valid, 0);
        check("midreset_onehot", grant_onehot, 0);
        rst_n = 1'b1;
        req   = 8'h21;
        expect_grant(0, 1, 1'b0);
        tick(1);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        req  = 8'h00;
        tick(3);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
